// File: rtl/icache_responder.sv
// icache_responder: direct-mapped read-only instruction cache, one-word lines, single-word refill
// ports: CLK/RST clock and sync active-high reset; imemREN/imemaddr fetch request -> ihit/imemload;
//        flush invalidates all lines; iREN/iaddr -> iwait/iload memory read; miss_count saturating miss tally
module icache_responder #(
  parameter int SETS   = 16,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              flush,
  output logic              ihit,
  output logic [31:0]       imemload,
  output logic              iREN,
  output logic [ADDR_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [31:0]       iload,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  typedef enum logic {IDLE, FILL} state_t;
  state_t            state, nstate;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [31:0]       data [SETS];
  logic [ADDR_W-3:0] miss_word;
  logic [IDX_W-1:0]  idx, midx;
  logic [TAG_W-1:0]  tag, mtag;
  logic              lookup, miss, done;
  logic              unused_byte_bits;
  assign unused_byte_bits = ^imemaddr[1:0];
  assign idx    = imemaddr[IDX_W+1:2];
  assign tag    = imemaddr[ADDR_W-1:IDX_W+2];
  assign midx   = miss_word[IDX_W-1:0];
  assign mtag   = miss_word[ADDR_W-3:IDX_W];
  assign lookup = valid[idx] && tags[idx] == tag;
  always_comb begin
    ihit     = (state == IDLE) && imemREN && lookup;
    imemload = ihit ? data[idx] : 32'd0;
    miss     = (state == IDLE) && imemREN && !lookup;
    iREN     = state == FILL;
    iaddr    = iREN ? {miss_word, 2'b00} : '0;
    done     = iREN && !iwait;
    nstate   = miss ? FILL : done ? IDLE : state;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      valid      <= '0;
      miss_count <= '0;
    end else begin
      state      <= nstate;
      miss_count <= miss_count + {{(CNT_W-1){1'b0}}, miss && !(&miss_count)};
      if (flush) valid <= '0;
      else if (done) valid[midx] <= 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (miss) miss_word <= imemaddr[ADDR_W-1:2];
    if (done) begin
      tags[midx] <= mtag;
      data[midx] <= iload;
    end
  end
endmodule
